// File: rtl/lanzones_fetch_pkg.sv
// Shared types and constants for the lanzones fetch stage.
package lanzones_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEF_RESET_PC = '0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_ent_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~(XLEN'(3));
  endfunction

endpackage

// File: rtl/lanzones_fetch_if.sv
// Fetch stage bundle: memory read port, decode handshake, branch redirect and fetch enable.
interface lanzones_fetch_if;
  import lanzones_fetch_pkg::*;

  logic            LEn;
  logic            RRdy;
  logic [XLEN-1:0] RAddr;
  logic            RVld;
  logic [XLEN-1:0] RData;
  logic            IVld;
  logic            IRdy;
  logic [XLEN-1:0] IData;
  logic [XLEN-1:0] IPc;
  logic            BrTaken;
  logic [XLEN-1:0] BrTarget;

  modport master (
    input  LEn, RVld, RData, IRdy, BrTaken, BrTarget,
    output RRdy, RAddr, IVld, IData, IPc
  );

  modport slave (
    output LEn, RVld, RData, IRdy, BrTaken, BrTarget,
    input  RRdy, RAddr, IVld, IData, IPc
  );

endinterface

// File: rtl/lanzones_fetch_buf.sv
// Small sync FIFO of {pc, instr} entries with push, pop, flush and occupancy count.
module lanzones_fetch_buf
  import lanzones_fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  fetch_ent_t    push_ent_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output fetch_ent_t    head_o,
  output logic [CW-1:0] count_o
);

  fetch_ent_t    mem_q [DEPTH];
  fetch_ent_t    mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_pop;

  assign do_pop = pop_i && (cnt_q != '0);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_q] = push_ent_i;
        wr_d        = wr_q + 1'b1;
      end
      if (do_pop) rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(push_i) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      // The fetch FSM only requests when a slot is free, so this must never fire.
      assert (!(push_i && !flush_i && cnt_q == CW'(DEPTH)));
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/lanzones_fetch.sv
// Instruction fetch: one outstanding word read, buffered results, branch redirect with flush.
module lanzones_fetch
  import lanzones_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEF_RESET_PC,
  parameter int              BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  lanzones_fetch_if.master  fif
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;

  logic            push, pop, flush;
  logic [CW-1:0]   count, cnt_after;
  logic            room_after;
  fetch_ent_t      head, push_ent;

  assign flush    = fif.BrTaken;
  assign pop      = fif.IVld && fif.IRdy;
  assign push     = (state_q == ST_WAIT) && fif.RVld && !drop_q && !fif.BrTaken;
  assign push_ent = '{pc: pc_q, instr: fif.RData};

  // Occupancy as it will be after this cycle's push/pop/flush; gates the next request.
  always_comb begin
    cnt_after = count;
    if (flush) cnt_after = '0;
    else       cnt_after = count + CW'(push) - CW'(pop);
  end
  assign room_after = cnt_after < CW'(BUF_DEPTH);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    case (state_q)
      ST_IDLE: begin
        if (fif.LEn && count < CW'(BUF_DEPTH) && !fif.BrTaken) state_d = ST_REQ;
      end
      ST_REQ: begin
        state_d = ST_WAIT;
        if (fif.BrTaken) drop_d = 1'b1;
      end
      ST_WAIT: begin
        if (fif.RVld) begin
          drop_d  = 1'b0;
          state_d = (fif.LEn && room_after) ? ST_REQ : ST_IDLE;
        end else if (fif.BrTaken) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (push)        pc_d = pc_q + XLEN'(4);
    if (fif.BrTaken) pc_d = align_word(fif.BrTarget);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  lanzones_fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .push_ent_i(push_ent),
    .pop_i     (pop),
    .flush_i   (flush),
    .head_o    (head),
    .count_o   (count)
  );

  assign fif.RRdy  = (state_q == ST_REQ);
  assign fif.RAddr = pc_q >> 2;
  assign fif.IVld  = (count != '0);
  assign fif.IData = head.instr;
  assign fif.IPc   = head.pc;

endmodule

// File: tb/tb_lanzones_fetch.sv
// Directed + random bench for lanzones_fetch; pops are checked against a sequential-stream model.
module tb_lanzones_fetch;
  import lanzones_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  lanzones_fetch_if fa();
  lanzones_fetch_if fb();

  lanzones_fetch #(.RESET_PC(32'h0), .BUF_DEPTH(2)) dut_a (
    .clk(clk), .rst(rst_a), .fif(fa.master));
  lanzones_fetch #(.RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(2)) dut_b (
    .clk(clk), .rst(rst_b), .fif(fb.master));

  int total = 0;
  int bad   = 0;
  int npop_a;
  int nreq;
  logic [31:0] mpc_a, mpc_b;
  logic [31:0] pcs_b[$];

  function automatic logic [31:0] memf(input logic [31:0] baddr);
    logic [31:0] w;
    w = baddr >> 2;
    case (w)
      32'd0:   return 32'h11;
      32'd1:   return 32'h22;
      32'd2:   return 32'h33;
      32'd3:   return 32'h44;
      32'd16:  return 32'h1600_ABCD;
      default: return (w * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endcase
  endfunction

  // Memory: answers exactly one cycle after each request strobe.
  always @(posedge clk) begin
    fa.RVld  <= fa.RRdy;
    fa.RData <= memf({fa.RAddr[29:0], 2'b00});
    fb.RVld  <= fb.RRdy;
    fb.RData <= memf({fb.RAddr[29:0], 2'b00});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Stream model: every accepted word is the next sequential word since the last redirect/reset.
  task automatic mon();
    if (rst_a) mpc_a = 32'h0;
    else begin
      chk("a_one_outstanding", 32'(fa.RRdy & fa.RVld), 32'h0);
      if (fa.BrTaken) mpc_a = fa.BrTarget & ~32'h3;
      else if (fa.IVld && fa.IRdy) begin
        chk("a_ipc", fa.IPc, mpc_a);
        chk("a_idata", fa.IData, memf(mpc_a));
        mpc_a += 32'd4;
        npop_a++;
      end
    end
    if (rst_b) mpc_b = 32'hFFFF_FFFC;
    else if (fb.IVld && fb.IRdy) begin
      chk("b_ipc", fb.IPc, mpc_b);
      chk("b_idata", fb.IData, memf(mpc_b));
      pcs_b.push_back(fb.IPc);
      mpc_b += 32'd4;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rrdy(input string tag);
    int n;
    n = 0;
    while (fa.RRdy !== 1'b1 && n < 20) begin cyc(); n++; end
    chk(tag, 32'(fa.RRdy), 32'h1);
  endtask

  task automatic wait_ivld(input string tag);
    int n;
    n = 0;
    while (fa.IVld !== 1'b1 && n < 20) begin cyc(); n++; end
    chk(tag, 32'(fa.IVld), 32'h1);
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    cyc();
    rst_a = 1'b0;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    fa.LEn = 1'b0; fa.IRdy = 1'b0; fa.BrTaken = 1'b0; fa.BrTarget = '0;
    fb.LEn = 1'b0; fb.IRdy = 1'b0; fb.BrTaken = 1'b0; fb.BrTarget = '0;
    repeat (3) cyc();

    chk("rst_rrdy",  32'(fa.RRdy), 32'h0);
    chk("rst_ivld",  32'(fa.IVld), 32'h0);
    chk("rst_idata", fa.IData, 32'h0);
    chk("rst_ipc",   fa.IPc, 32'h0);
    chk("rst_raddr", fa.RAddr, 32'h0);
    chk("rst_raddr_b", fb.RAddr, 32'h3FFF_FFFF);

    // Straight line: request every other cycle, four words retired in order.
    rst_a = 1'b0; fa.LEn = 1'b1; fa.IRdy = 1'b1; npop_a = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("t1_rrdy", 32'(fa.RRdy), 32'((i % 2) == 0));
    end
    chk("t1_npop", 32'(npop_a), 32'd4);

    // Backpressure: two words buffered, then no more requests.
    reset_a();
    fa.IRdy = 1'b0; nreq = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      nreq += int'(fa.RRdy);
    end
    chk("t2_nreq",  32'(nreq), 32'd2);
    chk("t2_rrdy",  32'(fa.RRdy), 32'h0);
    chk("t2_ivld",  32'(fa.IVld), 32'h1);
    chk("t2_head",  fa.IPc, 32'h0);
    fa.IRdy = 1'b1;
    wait_rrdy("t2_resume");
    chk("t2_raddr", fa.RAddr, 32'h2);
    repeat (12) cyc();
    chk("t2_progress", 32'(mpc_a > 32'h10), 32'h1);

    // Redirect while the request strobe is up.
    reset_a();
    repeat (5) cyc();
    wait_rrdy("t3_req");
    fa.BrTaken = 1'b1; fa.BrTarget = 32'h40;
    cyc();
    fa.BrTaken = 1'b0;
    wait_ivld("t3_ivld");
    chk("t3_ipc",   fa.IPc, 32'h40);
    chk("t3_idata", fa.IData, memf(32'h40));

    // Redirect in WAIT while the response is arriving and the buffer is occupied.
    reset_a();
    fa.IRdy = 1'b0;
    repeat (4) cyc();
    chk("t4_pre_ivld", 32'(fa.IVld), 32'h1);
    chk("t4_pre_wait", 32'(fa.RRdy), 32'h0);
    fa.BrTaken = 1'b1; fa.BrTarget = 32'h23;
    cyc();
    fa.BrTaken = 1'b0;
    chk("t4_flushed", 32'(fa.IVld), 32'h0);
    chk("t4_rrdy",    32'(fa.RRdy), 32'h1);
    chk("t4_raddr",   fa.RAddr, 32'h8);
    fa.IRdy = 1'b1;
    wait_ivld("t4_ivld");
    chk("t4_ipc", fa.IPc, 32'h20);

    // Reset while a response is in flight.
    reset_a();
    fa.IRdy = 1'b0;
    cyc(); cyc();
    chk("t5_wait", 32'(fa.RRdy), 32'h0);
    rst_a = 1'b1;
    cyc();
    rst_a = 1'b0; fa.LEn = 1'b0;
    cyc();
    chk("t5_ivld_a", 32'(fa.IVld), 32'h0);
    chk("t5_idle",   32'(fa.RRdy), 32'h0);
    fa.LEn = 1'b1;
    cyc();
    chk("t5_rrdy",   32'(fa.RRdy), 32'h1);
    chk("t5_raddr",  fa.RAddr, 32'h0);
    chk("t5_ivld_b", 32'(fa.IVld), 32'h0);
    fa.IRdy = 1'b1;

    // Random traffic: enable, backpressure and redirects.
    for (int i = 0; i < 400; i++) begin
      fa.LEn      = ($urandom_range(0, 9) != 0);
      fa.IRdy     = $urandom_range(0, 1) == 1;
      fa.BrTaken  = ($urandom_range(0, 19) == 0);
      fa.BrTarget = $urandom & 32'h3FF;
      cyc();
    end
    fa.BrTaken = 1'b0; fa.LEn = 1'b0; fa.IRdy = 1'b1;
    repeat (8) cyc();
    chk("rnd_drained", 32'(fa.IVld), 32'h0);

    // PC wrap from the top of the address space.
    rst_b = 1'b0; fb.LEn = 1'b1; fb.IRdy = 1'b1;
    repeat (12) cyc();
    chk("t6_npop", 32'(pcs_b.size() >= 2), 32'h1);
    if (pcs_b.size() >= 2) begin
      chk("t6_pc0", pcs_b[0], 32'hFFFF_FFFC);
      chk("t6_pc1", pcs_b[1], 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
